// File: rtl/btb_next_pc.sv
// Next-PC generator: direct-mapped BTB with 2-bit direction counters and the
// redirect/predict/sequential mux that feeds the PC register.
module btb_next_pc #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 32 - IDX_W - 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] o_next_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target
);

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic [1:0]       w_uctr;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;

    // Lookup reads the arrays directly, so a same-cycle update is only seen next cycle.
    assign w_idx = i_fetch_pc[IDX_W+1:2];
    assign w_tag = i_fetch_pc[31:IDX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign o_pred_taken  = w_hit && r_ctr[w_idx][1];
    assign o_pred_target = w_hit ? r_target[w_idx] : 32'd0;

    always_comb begin
        o_next_pc = i_fetch_pc + 32'd4;
        if (i_redirect)
            o_next_pc = i_redirect_pc;
        else if (o_pred_taken)
            o_next_pc = o_pred_target;
    end

    assign w_uidx    = i_upd_pc[IDX_W+1:2];
    assign w_utag    = i_upd_pc[31:IDX_W+2];
    assign w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_uctr    = r_ctr[w_uidx];
    assign w_ctr_inc = (w_uctr == 2'b11) ? 2'b11 : w_uctr + 2'd1;
    assign w_ctr_dec = (w_uctr == 2'b00) ? 2'b00 : w_uctr - 2'd1;

    // Valid bits and counters carry reset; a miss-taken update allocates weakly taken.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= 2'b01;
        end else if (i_upd_valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= i_upd_taken ? w_ctr_inc : w_ctr_dec;
            end else if (i_upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_ctr[w_uidx]   <= 2'b10;
            end
        end
    end

    // Tag/target have no reset; any taken update writes them (a hit rewrites the same tag).
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_upd_valid && i_upd_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= i_upd_target;
        end
    end

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: behavioural BTB model feeding an expected
// queue, plus literal spot checks of the directed scenarios.
module tb_btb_next_pc;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_fetch_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic [31:0] o_next_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;

    btb_next_pc #(.ENTRIES(ENTRIES)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_fetch_pc(i_fetch_pc),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc),
        .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
        .o_next_pc(o_next_pc), .o_pred_taken(o_pred_taken),
        .o_pred_target(o_pred_target)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // reference model
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tagv   [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic logic [64:0] model_out(input logic [31:0] f, input logic rd,
                                              input logic [31:0] rpc);
        int          k;
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        logic [31:0] nxt;
        k   = m_index(f);
        hit = m_valid[k] && (m_tagv[k] == m_tagof(f));
        tk  = hit && (m_ctr[k] >= 2);
        tgt = hit ? m_target[k] : 32'd0;
        if (rd)      nxt = rpc;
        else if (tk) nxt = tgt;
        else         nxt = f + 32'd4;
        return {tk, tgt, nxt};
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk,
                                         input logic [31:0] tgt);
        int k;
        k = m_index(pc);
        if (m_valid[k] && m_tagv[k] == m_tagof(pc)) begin
            if (tk) begin
                if (m_ctr[k] < 3) m_ctr[k]++;
                m_target[k] = tgt;
            end else if (m_ctr[k] > 0) begin
                m_ctr[k]--;
            end
        end else if (tk) begin
            m_valid[k]  = 1;
            m_tagv[k]   = m_tagof(pc);
            m_target[k] = tgt;
            m_ctr[k]    = 2;
        end
    endfunction

    // scoreboard
    logic [64:0] exp_q[$];
    string       tag_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one cycle: push model expectation, compare at negedge, step model at posedge
    task automatic drive(input string tag, input logic [31:0] f, input logic rd,
                         input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg);
        logic [64:0] got;
        i_fetch_pc    = f;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_upd_valid   = uv;
        i_upd_pc      = upc;
        i_upd_taken   = ut;
        i_upd_target  = utg;
        exp_q.push_back(model_out(f, rd, rpc));
        tag_q.push_back(tag);
        @(negedge i_clk);
        got = {o_pred_taken, o_pred_target, o_next_pc};
        check(tag_q.pop_front(), got, exp_q.pop_front());
        @(posedge i_clk);
        if (uv && !i_reset) model_update(upc, ut, utg);
        #1;
    endtask

    // literal check of a directed scenario, no clock edge
    task automatic spot(input string tag, input logic [31:0] f, input logic rd,
                        input logic [31:0] rpc, input logic exp_t, input logic [31:0] exp_n);
        i_fetch_pc    = f;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_upd_valid   = 1'b0;
        #1;
        check({tag, "_taken"}, o_pred_taken, exp_t);
        check({tag, "_next"}, o_next_pc, exp_n);
    endtask

    task automatic train(input string tag, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utg);
        drive(tag, 32'h1000, 1'b0, 32'h0, 1'b1, upc, ut, utg);
    endtask

    initial begin
        i_reset = 1'b1;
        i_fetch_pc = 32'h0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_upd_valid = 1'b0; i_upd_pc = 32'h0; i_upd_taken = 1'b0; i_upd_target = 32'h0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        spot("rst_init", 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // single taken allocation
        train("t2_train", 32'h40, 1'b1, 32'h80);
        spot("t2_hit", 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        spot("t2_seq", 32'h44, 1'b0, 32'h0, 1'b0, 32'h48);
        drive("t2_tgt", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // counter walk
        repeat (3) train("t3_inc", 32'h40, 1'b1, 32'h80);
        spot("t3_sat", 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        repeat (2) train("t3_dec", 32'h40, 1'b0, 32'h0);
        spot("t3_wnt", 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        repeat (2) train("t3_floor", 32'h40, 1'b0, 32'h0);
        drive("t3_valid", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        train("t3_from00", 32'h40, 1'b1, 32'h80);
        spot("t3_still", 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);

        // aliasing on index 0
        train("t4_alias", 32'h440, 1'b1, 32'h900);
        spot("t4_old", 32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
        spot("t4_new", 32'h440, 1'b0, 32'h0, 1'b1, 32'h900);
        train("t4_ntmiss", 32'h840, 1'b0, 32'h0);
        spot("t4_keep", 32'h440, 1'b0, 32'h0, 1'b1, 32'h900);
        spot("t4_840", 32'h840, 1'b0, 32'h0, 1'b0, 32'h844);
        drive("t4_sb", 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // redirect priority and wrap
        spot("t5_redir", 32'h440, 1'b1, 32'h200, 1'b1, 32'h200);
        spot("t5_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        drive("t5_sb", 32'h440, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);

        // async reset with trained entries; update under reset is dropped
        #1;
        i_reset = 1'b1;
        model_reset();
        spot("t1_drop", 32'h440, 1'b0, 32'h0, 1'b0, 32'h444);
        drive("t1_upd", 32'h100, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h300);
        i_reset = 1'b0;
        spot("t1_after", 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        drive("t1_sb", 32'h440, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // same-cycle lookup and update on a cold entry
        drive("t6_same", 32'h40, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h80);
        spot("t6_next", 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);

        // random traffic over a few tags per index; low pc bits are noise
        for (int n = 0; n < 300; n++) begin
            logic [31:0] f;
            logic [31:0] u;
            f = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            u = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            drive("rnd", f, ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 1) == 1), u, ($urandom_range(0, 2) != 0), $urandom);
        end

        if (exp_q.size() != 0) check("sb_drain", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
